// File: rtl/main_mem_arbiter_if.sv
// Bundle of the fetch port, data port and RAM-side signals between the
// main-memory arbiter and its requesters / RAM.
interface main_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
);
    logic                  in_f_req;
    logic [31:0]           in_f_addr;
    logic                  out_f_done;
    logic [DATA_WIDTH-1:0] out_f_rdata;

    logic                  in_d_req;
    logic                  in_d_we;
    logic [31:0]           in_d_addr;
    logic [DATA_WIDTH-1:0] in_d_wdata;
    logic                  out_d_done;
    logic [DATA_WIDTH-1:0] out_d_rdata;

    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic                  out_mem_we;
    logic [DATA_WIDTH-1:0] out_mem_wdata;
    logic [DATA_WIDTH-1:0] in_mem_rdata;

    modport slave (
        input  in_f_req, in_f_addr, in_d_req, in_d_we, in_d_addr, in_d_wdata, in_mem_rdata,
        output out_f_done, out_f_rdata, out_d_done, out_d_rdata,
        output out_mem_addr, out_mem_we, out_mem_wdata
    );

    modport master (
        output in_f_req, in_f_addr, in_d_req, in_d_we, in_d_addr, in_d_wdata, in_mem_rdata,
        input  out_f_done, out_f_rdata, out_d_done, out_d_rdata,
        input  out_mem_addr, out_mem_we, out_mem_wdata
    );
endinterface

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter time-sharing a single-port synchronous RAM between the
// instruction fetch port (F, read-only) and the data port (D).
module main_mem_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    main_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_last_d;
    logic                  r_grant_d;
    logic                  r_we;
    logic                  r_is_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_f_done;
    logic                  r_d_done;
    logic [DATA_WIDTH-1:0] r_f_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_any_req;
    logic                  w_pick_d;
    logic                  w_unused_addr_bits;

    // On a tie the port that did not win last time is served.
    assign w_any_req = bus.in_f_req | bus.in_d_req;
    assign w_pick_d  = bus.in_d_req & (~bus.in_f_req | ~r_last_d);

    assign w_unused_addr_bits = ^{bus.in_f_addr[1:0], bus.in_f_addr[31:ADDR_WIDTH+2],
                                  bus.in_d_addr[1:0], bus.in_d_addr[31:ADDR_WIDTH+2]};

    assign bus.out_mem_addr  = r_mem_addr;
    assign bus.out_mem_we    = r_we & ~rst;
    assign bus.out_mem_wdata = r_mem_wdata;
    assign bus.out_f_done    = r_f_done;
    assign bus.out_f_rdata   = r_f_rdata;
    assign bus.out_d_done    = r_d_done;
    assign bus.out_d_rdata   = r_d_rdata;

    // Access sequencer: grant, one-cycle RAM access, capture, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_d    <= 1'b0;
            r_grant_d   <= 1'b0;
            r_we        <= 1'b0;
            r_is_wr     <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_WIDTH{1'b0}};
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_f_rdata   <= {DATA_WIDTH{1'b0}};
            r_d_rdata   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d <= w_pick_d;
                        r_last_d  <= w_pick_d;
                        r_we      <= w_pick_d & bus.in_d_we;
                        r_is_wr   <= w_pick_d & bus.in_d_we;
                        if (w_pick_d) begin
                            r_mem_addr  <= bus.in_d_addr[ADDR_WIDTH+1:2];
                            r_mem_wdata <= bus.in_d_wdata;
                        end else begin
                            r_mem_addr  <= bus.in_f_addr[ADDR_WIDTH+1:2];
                            r_mem_wdata <= r_mem_wdata;
                        end
                        r_state <= S_ACCESS;
                    end else begin
                        r_we    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                // The RAM samples at the end of this cycle, so the write
                // strobe must not leak into CAPTURE.
                S_ACCESS: begin
                    r_we    <= 1'b0;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_we <= 1'b0;
                    if (r_grant_d) begin
                        r_d_rdata <= r_is_wr ? {DATA_WIDTH{1'b0}} : bus.in_mem_rdata;
                        r_d_done  <= 1'b1;
                    end else begin
                        r_f_rdata <= bus.in_mem_rdata;
                        r_f_done  <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_f_done <= 1'b0;
                    r_d_done <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
